// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single memory backend between an instruction-fetch port (IF) and a
// data-memory port (DM). One transaction is in flight at a time and moves
// through IDLE -> BUSY -> RESP. A wait counter aborts a BUSY transaction that
// receives no mem_ack within TIMEOUT cycles. The aborted port gets
// 32'hDEADBEEF, and err pulses alongside its ready.
//
// Build option:
//   ARB_RR_EN  defined   : simultaneous requests are granted round-robin,
//                          starting with DM after reset.
//              undefined : fixed priority, DM wins over IF.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_ready)
//   if_rdata/if_ready              fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_type               data request bundle (held until dm_ready)
//   dm_rdata/dm_ready              load data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_type             backend request bundle
//   mem_rdata/mem_ack              backend response
//   stall                          a requester is waiting this cycle
//   err                            one-cycle pulse on timeout abort
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [2:0]  dm_type,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_type,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        err
);

   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_BUSY    = 2'd1;
   localparam logic [1:0]  ST_RESP    = 2'd2;
   localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
   // Fetches are always full-word reads.
   localparam logic [2:0]  IF_TYPE    = 3'd2;
   // The counter value at which a BUSY cycle without ack is the last one allowed.
   localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);

   logic [1:0] state_r;
   logic       grant_dm_r;
   logic [7:0] wait_cnt_r;
   logic       grant_dm_s;
   logic       any_req_s;

`ifdef ARB_RR_EN
   // 1 when DM received the most recent grant. Cleared on reset, so DM is
   // favoured first.
   logic       rr_last_dm_r;
`endif

   // Arbitration decision; only consumed while in IDLE.
   always_comb begin
      grant_dm_s = 1'b0;
      any_req_s  = if_req | dm_req;
      if (dm_req && if_req) begin
`ifdef ARB_RR_EN
         grant_dm_s = ~rr_last_dm_r;
`else
         grant_dm_s = 1'b1;
`endif
      end else begin
         grant_dm_s = dm_req;
      end
   end

   // A requester is stalled while its request is up and its ready is not.
   assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

`ifdef ARB_RR_EN
   // Round-robin pointer: remember which port won the latest arbitration.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_last_dm_r <= 1'b0;
      end else if (state_r == ST_IDLE && any_req_s) begin
         rr_last_dm_r <= grant_dm_s;
      end else begin
         rr_last_dm_r <= rr_last_dm_r;
      end
   end
`endif

   // Transaction state machine with registered backend bundle and port outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         grant_dm_r <= 1'b0;
         wait_cnt_r <= 8'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         mem_type   <= 3'd0;
         if_rdata   <= 32'd0;
         dm_rdata   <= 32'd0;
         if_ready   <= 1'b0;
         dm_ready   <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               err      <= 1'b0;
               if (any_req_s) begin
                  grant_dm_r <= grant_dm_s;
                  wait_cnt_r <= 8'd0;
                  mem_req    <= 1'b1;
                  state_r    <= ST_BUSY;
                  if (grant_dm_s) begin
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     mem_type  <= dm_type;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= 32'd0;
                     mem_type  <= IF_TYPE;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               // Ack takes precedence over a timeout in the same cycle.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state_r <= ST_RESP;
                  if (grant_dm_r) begin
                     dm_rdata <= mem_rdata;
                     dm_ready <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end
               end else if (wait_cnt_r == WAIT_LAST) begin
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  err        <= 1'b1;
                  wait_cnt_r <= wait_cnt_r + 8'd1;
                  state_r    <= ST_RESP;
                  if (grant_dm_r) begin
                     dm_rdata <= ABORT_DATA;
                     dm_ready <= 1'b1;
                  end else begin
                     if_rdata <= ABORT_DATA;
                     if_ready <= 1'b1;
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            ST_RESP: begin
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               err      <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               mem_req  <= 1'b0;
               mem_we   <= 1'b0;
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter, built with TIMEOUT=4. Each scenario task
// drives its stimulus and checks the expected values it computes itself.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [2:0]  dm_type;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_type;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_type(dm_type), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_type(mem_type),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_type = 3'd0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
      tick(); tick();
      n_cmp++;
      if ({mem_req, mem_we, if_ready, dm_ready, err, stall} !== 6'b000000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, if_ready, dm_ready, err, stall});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata, mem_type} !== 67'd0) begin
         n_bad++;
         $display("FAIL reset_bundle: got %h want 0", {mem_addr, mem_wdata, mem_type});
      end
      n_cmp++;
      if ({if_rdata, dm_rdata} !== 64'd0) begin
         n_bad++;
         $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_if_only();
      if_req = 1'b1; if_addr = 32'h10;
      tick(); // BUSY cycle 1
      n_cmp++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
         n_bad++;
         $display("FAIL if_bundle: got req=%b we=%b addr=%h want 1 0 00000010", mem_req, mem_we, mem_addr);
      end
      n_cmp++;
      if ({stall, if_ready} !== 2'b10) begin
         n_bad++;
         $display("FAIL if_stall_b1: got stall=%b rdy=%b want 1 0", stall, if_ready);
      end
      if_addr = 32'h999; // must be ignored while BUSY
      tick(); // BUSY cycle 2
      n_cmp++;
      if ({mem_req, mem_addr, stall} !== {1'b1, 32'h10, 1'b1}) begin
         n_bad++;
         $display("FAIL if_hold_b2: got req=%b addr=%h stall=%b want 1 00000010 1", mem_req, mem_addr, stall);
      end
      tick(); // BUSY cycle 3: ack two cycles after mem_req first rose
      mem_ack = 1'b1; mem_rdata = 32'h00500093;
      tick(); // RESP
      mem_ack = 1'b0; mem_rdata = 32'hFFFFFFFF;
      n_cmp++;
      if ({if_ready, dm_ready, err, mem_req, stall} !== 5'b10000) begin
         n_bad++;
         $display("FAIL if_resp_ctrl: got %b want 10000", {if_ready, dm_ready, err, mem_req, stall});
      end
      n_cmp++;
      if (if_rdata !== 32'h00500093) begin
         n_bad++;
         $display("FAIL if_rdata: got %h want 00500093", if_rdata);
      end
      if_req = 1'b0;
      tick(); // IDLE
      n_cmp++;
      if ({if_ready, mem_req, if_rdata} !== {1'b0, 1'b0, 32'h00500093}) begin
         n_bad++;
         $display("FAIL if_after: got rdy=%b req=%b rdata=%h want 0 0 00500093", if_ready, mem_req, if_rdata);
      end
   endtask

   task automatic test_store();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h12345678; dm_type = 3'd2;
      tick(); // BUSY cycle 1
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_type} !== {1'b1, 1'b1, 32'h100, 32'h12345678, 3'd2}) begin
         n_bad++;
         $display("FAIL store_bundle: got req=%b we=%b addr=%h wd=%h type=%0d want 1 1 00000100 12345678 2",
                  mem_req, mem_we, mem_addr, mem_wdata, mem_type);
      end
      mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
      tick(); // RESP
      mem_ack = 1'b0;
      n_cmp++;
      if ({dm_ready, if_ready, err} !== 3'b100) begin
         n_bad++;
         $display("FAIL store_ready: got dm=%b if=%b err=%b want 1 0 0", dm_ready, if_ready, err);
      end
      dm_req = 1'b0; dm_we = 1'b0;
      tick(); // IDLE
      n_cmp++;
      if ({dm_ready, if_ready, mem_req} !== 3'b000) begin
         n_bad++;
         $display("FAIL store_after: got dm=%b if=%b req=%b want 0 0 0", dm_ready, if_ready, mem_req);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_dm;
`ifdef ARB_RR_EN
      exp_dm = 4'b0101; // bit i = transaction i: DM, IF, DM, IF
`else
      exp_dm = 4'b0111; // DM, DM, DM, then IF once DM stops asking
`endif
      // Fresh reset so the round-robin pointer starts favouring DM.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if_req = 1'b1; if_addr = 32'h2000;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
      for (int i = 0; i < 4; i++) begin
         tick(); // BUSY cycle 1
         n_cmp++;
         if (mem_addr !== (exp_dm[i] ? 32'h3000 : 32'h2000)) begin
            n_bad++;
            $display("FAIL sim_grant_%0d: got addr=%h want %h", i, mem_addr, exp_dm[i] ? 32'h3000 : 32'h2000);
         end
         mem_ack = 1'b1; mem_rdata = 32'h100 + 32'(i);
         tick(); // RESP
         mem_ack = 1'b0;
         n_cmp++;
         if ({dm_ready, if_ready} !== {exp_dm[i], ~exp_dm[i]}) begin
            n_bad++;
            $display("FAIL sim_ready_%0d: got dm=%b if=%b want %b %b", i, dm_ready, if_ready, exp_dm[i], ~exp_dm[i]);
         end
         if (i == 2) dm_req = 1'b0;
         if (i == 3) if_req = 1'b0;
         tick(); // IDLE
      end
   endtask

   task automatic test_timeout();
      if_req = 1'b1; if_addr = 32'h40;
      for (int k = 1; k <= 4; k++) begin
         tick(); // BUSY cycle k, no ack
         n_cmp++;
         if ({mem_req, err, if_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL to_busy_%0d: got req=%b err=%b rdy=%b want 1 0 0", k, mem_req, err, if_ready);
         end
      end
      tick(); // RESP after abort
      n_cmp++;
      if ({if_ready, err, mem_req, if_rdata} !== {1'b1, 1'b1, 1'b0, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL to_abort: got rdy=%b err=%b req=%b rdata=%h want 1 1 0 deadbeef", if_ready, err, mem_req, if_rdata);
      end
      if_req = 1'b0;
      tick(); // IDLE
      n_cmp++;
      if ({if_ready, err} !== 2'b00) begin
         n_bad++;
         $display("FAIL to_after: got rdy=%b err=%b want 0 0", if_ready, err);
      end
      // Ack in the 4th BUSY cycle wins over the timeout.
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      tick(); tick(); tick(); tick(); // BUSY cycle 4
      n_cmp++;
      if (mem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL to_ack4_req: got %b want 1", mem_req);
      end
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick(); // RESP
      mem_ack = 1'b0;
      n_cmp++;
      if ({dm_ready, err, dm_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
         n_bad++;
         $display("FAIL to_ack4: got rdy=%b err=%b rdata=%h want 1 0 cafef00d", dm_ready, err, dm_rdata);
      end
      dm_req = 1'b0;
      tick(); // IDLE
   endtask

   task automatic test_reset_busy();
      if_req = 1'b1; if_addr = 32'h44;
      tick(); // BUSY cycle 1
      tick(); // BUSY cycle 2
      reset = 1'b1; if_req = 1'b0;
      tick(); // back in IDLE
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h55555555; // late ack, must be ignored
      n_cmp++;
      if ({mem_req, if_ready, dm_ready, err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rb_first: got %b want 0000", {mem_req, if_ready, dm_ready, err});
      end
      tick();
      mem_ack = 1'b0;
      n_cmp++;
      if ({mem_req, mem_we, if_ready, dm_ready, err, stall} !== 6'b000000) begin
         n_bad++;
         $display("FAIL rb_ctrl: got %b want 000000", {mem_req, mem_we, if_ready, dm_ready, err, stall});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata, mem_type, if_rdata, dm_rdata} !== 131'd0) begin
         n_bad++;
         $display("FAIL rb_data: got %h want 0", {mem_addr, mem_wdata, mem_type, if_rdata, dm_rdata});
      end
      tick();
      n_cmp++;
      if ({if_ready, err, if_rdata} !== {1'b0, 1'b0, 32'd0}) begin
         n_bad++;
         $display("FAIL rb_late: got rdy=%b err=%b rdata=%h want 0 0 0", if_ready, err, if_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_if_only();
      test_store();
      test_simultaneous();
      test_timeout();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
